// File: rtl/pipeline_latealu.sv
// Late-stage ALU: iterative signed multiplier feeding HI/LO, plus a small
// coprocessor-0 register file (Count, Status, Cause, EPC) with syscall/eret.
module pipeline_latealu (
  input  logic        clk,
  input  logic        rst,
  input  logic        latealu_enable,
  input  logic [5:0]  latealu_op,
  input  logic [31:0] latealu_a0,
  input  logic [31:0] latealu_a1,
  output logic [31:0] latealu_mult_hi,
  output logic [31:0] latealu_mult_lo,
  output logic [31:0] latealu_cpr14,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result_value,
  output logic [2:0]  exception
);

  localparam logic [5:0] OP_MULT    = 6'b000100;
  localparam logic [5:0] OP_MTHI    = 6'b000101;
  localparam logic [5:0] OP_MTLO    = 6'b000110;
  localparam logic [5:0] OP_SYSCALL = 6'b001000;
  localparam logic [5:0] OP_ERET    = 6'b001001;
  localparam logic [5:0] OP_MFC0    = 6'b001010;
  localparam logic [5:0] OP_MTC0    = 6'b001011;

  localparam logic [4:0] CPR_COUNT  = 5'd9;
  localparam logic [4:0] CPR_STATUS = 5'd12;
  localparam logic [4:0] CPR_CAUSE  = 5'd13;
  localparam logic [4:0] CPR_EPC    = 5'd14;

  typedef enum logic [0:0] {
    MUL_IDLE,
    MUL_RUN
  } mul_state_e;

  mul_state_e  mulState_q;
  logic [1:0]  step_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] acc_q;
  logic        neg_q;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        resultValid_q, resultValid_d;
  logic [31:0] resultValue_q, resultValue_d;
  logic [2:0]  exception_q, exception_d;

  logic        accept;
  logic        multStart;
  logic        multDone;
  logic [31:0] magA;
  logic [31:0] magB;
  logic [63:0] partial;
  logic [63:0] accSum;
  logic [63:0] finalProd;
  logic [4:0]  cprIdx;
  logic [31:0] cprRead;

  assign accept    = latealu_enable && (mulState_q == MUL_IDLE);
  assign multStart = accept && (latealu_op == OP_MULT);
  assign magA      = latealu_a0[31] ? (32'd0 - latealu_a0) : latealu_a0;
  assign magB      = latealu_a1[31] ? (32'd0 - latealu_a1) : latealu_a1;
  assign partial   = mcand_q * {56'd0, mplier_q[7:0]};
  assign accSum    = acc_q + partial;
  assign finalProd = neg_q ? (64'd0 - accSum) : accSum;
  assign multDone  = (mulState_q == MUL_RUN) && (step_q == 2'd3);
  assign cprIdx    = latealu_a0[4:0];

  // Unsigned shift-add over magnitudes, one multiplier byte per busy cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mulState_q <= MUL_IDLE;
      step_q     <= 2'd0;
      mcand_q    <= 64'd0;
      mplier_q   <= 32'd0;
      acc_q      <= 64'd0;
      neg_q      <= 1'b0;
    end else begin
      case (mulState_q)
        MUL_IDLE: begin
          if (multStart) begin
            mcand_q    <= {32'd0, magA};
            mplier_q   <= magB;
            acc_q      <= 64'd0;
            neg_q      <= latealu_a0[31] ^ latealu_a1[31];
            step_q     <= 2'd0;
            mulState_q <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc_q    <= accSum;
          mcand_q  <= mcand_q << 8;
          mplier_q <= mplier_q >> 8;
          step_q   <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            mulState_q <= MUL_IDLE;
          end
        end
        default: mulState_q <= MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    cprRead = 32'd0;
    case (cprIdx)
      CPR_COUNT:  cprRead = count_q;
      CPR_STATUS: cprRead = {30'd0, status_q};
      CPR_CAUSE:  cprRead = cause_q;
      CPR_EPC:    cprRead = epc_q;
      default:    cprRead = 32'd0;
    endcase
  end

  // An accepted op and a mult completion never coincide: accept needs idle.
  always_comb begin
    hi_d          = hi_q;
    lo_d          = lo_q;
    count_d       = count_q + 32'd1;
    status_d      = status_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    resultValid_d = 1'b0;
    resultValue_d = resultValue_q;
    exception_d   = 3'b000;

    if (multDone) begin
      hi_d = finalProd[63:32];
      lo_d = finalProd[31:0];
    end

    if (accept) begin
      case (latealu_op)
        OP_MULT: ;
        OP_MTHI: hi_d = latealu_a0;
        OP_MTLO: lo_d = latealu_a0;
        OP_SYSCALL: begin
          epc_d       = latealu_a0;
          cause_d     = 32'h0000_0020;
          status_d[1] = 1'b1;
        end
        OP_ERET: status_d[1] = 1'b0;
        OP_MFC0: begin
          resultValid_d = 1'b1;
          resultValue_d = cprRead;
        end
        OP_MTC0: begin
          case (cprIdx)
            CPR_COUNT:  count_d  = latealu_a1;
            CPR_STATUS: status_d = latealu_a1[1:0];
            CPR_EPC:    epc_d    = latealu_a1;
            default: ;
          endcase
        end
        default: exception_d = 3'b001;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      count_q       <= 32'd0;
      status_q      <= 2'd0;
      cause_q       <= 32'd0;
      epc_q         <= 32'd0;
      resultValid_q <= 1'b0;
      resultValue_q <= 32'd0;
      exception_q   <= 3'b000;
    end else begin
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      count_q       <= count_d;
      status_q      <= status_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      resultValid_q <= resultValid_d;
      resultValue_q <= resultValue_d;
      exception_q   <= exception_d;
    end
  end

  assign latealu_mult_hi = hi_q;
  assign latealu_mult_lo = lo_q;
  assign latealu_cpr14   = epc_q;
  assign busy            = (mulState_q == MUL_RUN);
  assign result_valid    = resultValid_q;
  assign result_value    = resultValue_q;
  assign exception       = exception_q;

endmodule

// File: doc/pipeline_latealu.md
PIPELINE_LATEALU -- requirements
Module: pipeline_latealu

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous, active-low; the only reset.
REQ-003 SHALL expose: latealu_enable  input  1  op valid this cycle.
REQ-004 SHALL expose: latealu_op  input  6  op code: 000100 mult, 000101 mthi, 000110 mtlo, 001000 syscall, 001001 eret, 001010 mfc0, 001011 mtc0.
REQ-005 SHALL expose: latealu_a0  input  32  operand 0 (mult rs / mthi-mtlo value / syscall PC / CPR index in bits 4:0).
REQ-006 SHALL expose: latealu_a1  input  32  operand 1 (mult rt / mtc0 value).
REQ-007 SHALL expose: latealu_mult_hi, latealu_mult_lo  output  32 each  HI/LO registers.
REQ-008 SHALL expose: latealu_cpr14  output  32  EPC.
REQ-009 SHALL expose: busy  output  1  multiply in progress; upstream stalls and re-presents the op.
REQ-010 SHALL expose: result_valid  output  1; result_value  output  32  mfc0 read data.
REQ-011 SHALL expose: exception  output  3  001 = bad op, else 000.

Function
REQ-012 SHALL accept an op only on a rising edge where latealu_enable=1 and busy=0; an op presented while busy=1 is ignored, with no state change.
REQ-013 SHALL perform mult as a signed 32x32->64 product: magnitudes taken at acceptance, 8 multiplier bits consumed per cycle over exactly 4 cycles, sign applied at completion.
REQ-014 SHALL assert busy from the acceptance edge k through edge k+4; at edge k+4, HI<=product[63:32] and LO<=product[31:0] simultaneously, and busy falls.
REQ-015 SHALL hold HI/LO at their prior values during busy cycles.
REQ-016 SHALL, for mthi/mtlo, write a0 to HI/LO at the acceptance edge (1-cycle latency).
REQ-017 SHALL implement CPRs: 9 Count, 12 Status, 13 Cause, 14 EPC; all others read 0 and ignore writes.
REQ-018 SHALL increment Count by 1 every cycle, wrapping FFFFFFFF->0; an mtc0 to 9 overrides the increment in that cycle.
REQ-019 SHALL, for syscall: EPC<=a0, Cause<=0x00000020 (ExcCode 8 in bits 6:2), Status[1] (EXL)<=1, all in one edge.
REQ-020 SHALL, for eret, clear Status[1] only; EPC is unchanged.
REQ-021 SHALL, for mfc0, register result_value=CPR[a0[4:0]] (pre-update value) with result_valid=1 for exactly one cycle after acceptance.
REQ-022 SHALL, for mtc0, write a1 to CPR[a0[4:0]] at the acceptance edge; Status is writable in bits 1:0 only, Cause is read-only (write ignored).
REQ-023 SHALL, for an unlisted op code, pulse exception=001 for one cycle and change no state.
REQ-024 SHALL drive exception and result_valid to 0 in every cycle with no accepted op of that kind.

Reset
REQ-025 SHALL, on rst low (asynchronous): HI=LO=0, Count=Status=Cause=EPC=0, busy=0, result_valid=0, result_value=0, exception=000, and any in-flight mult is abandoned.
REQ-026 SHALL resume counting and accept ops on the first rising edge after rst deasserts.

Verification
REQ-027 SHALL cover: mult a0=0xFFFFFFFD, a1=7 -> busy high 4 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-028 SHALL cover: mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0; mthi 0x1234 issued during busy is ignored, and HI remains 0x40000000.
REQ-029 SHALL cover: syscall a0=0x00400020 -> cpr14=0x00400020, Cause=0x20, Status=0x2; then eret -> Status=0x0 and cpr14 unchanged.
REQ-030 SHALL cover: mtc0 index 9 value 100, then mfc0 index 9 three cycles later -> result_value=102 with result_valid for one cycle.
REQ-031 SHALL cover: rst low at the second busy cycle of a mult -> busy=0 and HI=LO=0 immediately; no late HI/LO update after release.
REQ-032 SHALL cover: op 111111 -> exception=001 for one cycle; HI, LO and all CPRs unchanged.
